// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. The decode-stage PC is looked up combinationally and the
//   result steers fetch. Resolved conditional branches and JALs from
//   execute train the table.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   i_lookup_valid/pc   decode-stage instruction to predict
//   o_pred_taken        redirect fetch to o_pred_target
//   o_pred_target       cached target (0 on miss)
//   o_pred_hit          valid tag match at the looked-up index
//   i_upd_*             resolved branch/JAL training port

// One table entry. The owning top selects it when the update index matches;
// the entry decides for itself whether that update is a hit or an allocate.
module btb_entry #(
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sel,
  input  logic [TAG_W-1:0] i_upd_tag,
  input  logic             i_upd_is_jal,
  input  logic             i_upd_taken,
  input  logic [31:0]      i_upd_target,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_target,
  output logic [1:0]       o_ctr,
  output logic             o_jal
);
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_target;
  logic [1:0]       r_ctr;
  logic             r_jal;

  logic       w_hit;
  logic       w_alloc;
  logic [1:0] w_ctr_inc;
  logic [1:0] w_ctr_dec;

  assign w_hit     = r_valid && (r_tag == i_upd_tag);
  assign w_alloc   = i_sel && !w_hit && i_upd_taken;
  assign w_ctr_inc = (r_ctr == 2'd3) ? 2'd3 : r_ctr + 2'd1;
  assign w_ctr_dec = (r_ctr == 2'd0) ? 2'd0 : r_ctr - 2'd1;

  // Only the valid bit is reset; the payload is never observed while invalid.
  always_ff @(posedge clk) begin
    if (rst)          r_valid <= 1'b0;
    else if (w_alloc) r_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && i_sel) begin
      if (w_hit) begin
        if (i_upd_is_jal) begin
          r_ctr    <= 2'd3;
          r_jal    <= 1'b1;
          r_target <= i_upd_target;
        end else if (i_upd_taken) begin
          r_ctr    <= w_ctr_inc;
          r_target <= i_upd_target;
        end else begin
          r_ctr    <= w_ctr_dec;
        end
      end else if (i_upd_taken) begin
        r_tag    <= i_upd_tag;
        r_target <= i_upd_target;
        r_jal    <= i_upd_is_jal;
        r_ctr    <= i_upd_is_jal ? 2'd3 : 2'd2;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_tag    = r_tag;
  assign o_target = r_target;
  assign o_ctr    = r_ctr;
  assign o_jal    = r_jal;
endmodule

module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_lookup_valid,
  input  logic [31:0] i_lookup_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic        o_pred_hit,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_is_jal,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target
);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0]            w_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] w_tag;
  logic [ENTRIES-1:0][31:0]      w_target;
  logic [ENTRIES-1:0][1:0]       w_ctr;
  logic [ENTRIES-1:0]            w_jal;
  logic [ENTRIES-1:0]            w_sel;

  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;

  assign w_upd_idx = i_upd_pc[IDX_W+1:2];
  assign w_upd_tag = i_upd_pc[31:IDX_W+2];
  assign w_lk_idx  = i_lookup_pc[IDX_W+1:2];
  assign w_lk_tag  = i_lookup_pc[31:IDX_W+2];

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    assign w_sel[e] = i_upd_valid && (w_upd_idx == IDX_W'(e));

    btb_entry #(.TAG_W(TAG_W)) u_ent (
      .clk          (clk),
      .rst          (rst),
      .i_sel        (w_sel[e]),
      .i_upd_tag    (w_upd_tag),
      .i_upd_is_jal (i_upd_is_jal),
      .i_upd_taken  (i_upd_taken),
      .i_upd_target (i_upd_target),
      .o_valid      (w_valid[e]),
      .o_tag        (w_tag[e]),
      .o_target     (w_target[e]),
      .o_ctr        (w_ctr[e]),
      .o_jal        (w_jal[e])
    );
  end

  // Reads registered state only, so a same-cycle update is never seen.
  // Gated by rst so outputs are quiet for the whole reset window, including
  // the first cycle before the valid bits have cleared.
  assign w_lk_hit = !rst && i_lookup_valid && w_valid[w_lk_idx] &&
                    (w_tag[w_lk_idx] == w_lk_tag);

  assign o_pred_hit    = w_lk_hit;
  assign o_pred_taken  = w_lk_hit && (w_jal[w_lk_idx] || w_ctr[w_lk_idx][1]);
  assign o_pred_target = w_lk_hit ? w_target[w_lk_idx] : 32'd0;
endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_jal = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_target_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_lookup_valid (lookup_valid),
    .i_lookup_pc    (lookup_pc),
    .o_pred_taken   (pred_taken),
    .o_pred_target  (pred_target),
    .o_pred_hit     (pred_hit),
    .i_upd_valid    (upd_valid),
    .i_upd_pc       (upd_pc),
    .i_upd_is_jal   (upd_is_jal),
    .i_upd_taken    (upd_taken),
    .i_upd_target   (upd_target)
  );

  // Reference table: one record per index, counter kept as a plain int.
  bit          m_vld [ENTRIES];
  int unsigned m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_ctr [ENTRIES];
  bit          m_jal [ENTRIES];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    int i;
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) m_vld[k] = 0;
    end else if (upd_valid) begin
      i = idx_of(upd_pc);
      if (m_vld[i] && m_tag[i] == tag_of(upd_pc)) begin
        if (upd_is_jal) begin
          m_ctr[i] = 3; m_jal[i] = 1; m_tgt[i] = upd_target;
        end else if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_vld[i] = 1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target;
        m_jal[i] = upd_is_jal; m_ctr[i] = upd_is_jal ? 3 : 2;
      end
    end
  endtask

  // Entered just after a rising edge with inputs already driven. Checks the
  // lookup mid-cycle against the pre-update model, then clocks the update.
  task automatic step();
    int  i;
    bit  h;
    @(negedge clk);
    i = idx_of(lookup_pc);
    h = !rst && lookup_valid && m_vld[i] && m_tag[i] == tag_of(lookup_pc);
    chk("hit",    {31'd0, pred_hit},   {31'd0, h});
    chk("taken",  {31'd0, pred_taken}, {31'd0, h && (m_jal[i] || m_ctr[i] >= 2)});
    chk("target", pred_target,         h ? m_tgt[i] : 32'd0);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input bit jal, input bit tk, input logic [31:0] tg);
    upd_valid = 1; upd_pc = pc; upd_is_jal = jal; upd_taken = tk; upd_target = tg;
    lookup_valid = 0;
    step();
    upd_valid = 0;
  endtask

  // Lookup with spec-derived constants checked directly, then a model step.
  task automatic look(input logic [31:0] pc, input bit eh, input bit et, input logic [31:0] etg);
    upd_valid = 0; lookup_valid = 1; lookup_pc = pc;
    #1;
    chk("dir_hit",    {31'd0, pred_hit},   {31'd0, eh});
    chk("dir_taken",  {31'd0, pred_taken}, {31'd0, et});
    chk("dir_target", pred_target,         etg);
    step();
  endtask

  initial begin
    @(posedge clk); #1;
    rst = 1; lookup_valid = 1; lookup_pc = 32'h4000_0010;
    step(); step();
    rst = 0;
    look(32'h4000_0010, 0, 0, 0);

    // Allocate, strengthen, saturate high.
    upd(32'h4000_0010, 0, 1, 32'h4000_0100);
    look(32'h4000_0010, 1, 1, 32'h4000_0100);
    upd(32'h4000_0010, 0, 1, 32'h4000_0100);
    upd(32'h4000_0010, 0, 1, 32'h4000_0100);
    // Hysteresis: 3->2 still taken, 2->1 not taken, then saturate at 0.
    upd(32'h4000_0010, 0, 0, 32'h0);
    look(32'h4000_0010, 1, 1, 32'h4000_0100);
    upd(32'h4000_0010, 0, 0, 32'h0);
    look(32'h4000_0010, 1, 0, 32'h4000_0100);
    upd(32'h4000_0010, 0, 0, 32'h0);
    upd(32'h4000_0010, 0, 0, 32'h0);
    upd(32'h4000_0010, 0, 1, 32'h4000_0104);
    look(32'h4000_0010, 1, 0, 32'h4000_0104);  // 0 -> 1 proves no wrap to 3

    // Aliasing at index 4.
    upd(32'h4000_0050, 0, 0, 32'h1234_5678);
    look(32'h4000_0010, 1, 0, 32'h4000_0104);
    upd(32'h4000_0050, 0, 1, 32'h4000_0500);
    look(32'h4000_0010, 0, 0, 0);
    look(32'h4000_0050, 1, 1, 32'h4000_0500);

    // Same-cycle lookup/update collision.
    lookup_valid = 1; lookup_pc = 32'h4000_0020;
    upd_valid = 1; upd_pc = 32'h4000_0020; upd_is_jal = 1; upd_taken = 1;
    upd_target = 32'h4000_0200;
    #1;
    chk("coll_hit", {31'd0, pred_hit}, 32'd0);
    step();
    look(32'h4000_0020, 1, 1, 32'h4000_0200);

    // Reset mid-operation with an update in flight.
    rst = 1; lookup_valid = 1; lookup_pc = 32'h4000_0020;
    upd_valid = 1; upd_pc = 32'h4000_0030; upd_is_jal = 0; upd_taken = 1;
    upd_target = 32'h4000_0300;
    #1;
    chk("rst_hit",    {31'd0, pred_hit},   32'd0);
    chk("rst_taken",  {31'd0, pred_taken}, 32'd0);
    chk("rst_target", pred_target,         32'd0);
    step();
    rst = 0; upd_valid = 0;
    look(32'h4000_0020, 0, 0, 0);
    look(32'h4000_0050, 0, 0, 0);
    look(32'h4000_0030, 0, 0, 0);

    // Random traffic over a small pool of tags so hits and aliases are common.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] base [3];
      base[0] = 32'h4000_0000; base[1] = 32'h4000_1000; base[2] = 32'h8000_0000;
      rst          = ($urandom_range(0, 99) == 0);
      lookup_valid = ($urandom_range(0, 7) != 0);
      lookup_pc    = base[$urandom_range(0, 2)] | ($urandom_range(0, ENTRIES-1) << 2)
                     | $urandom_range(0, 3);
      upd_valid    = ($urandom_range(0, 2) != 0);
      upd_pc       = base[$urandom_range(0, 2)] | ($urandom_range(0, ENTRIES-1) << 2)
                     | $urandom_range(0, 3);
      upd_is_jal   = ($urandom_range(0, 4) == 0);
      upd_taken    = upd_is_jal | $urandom_range(0, 1);
      upd_target   = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters. It sits directly upstream of the program counter and drives its `target_taken`/`target` inputs. It looks up the PC of the instruction currently in decode and predicts whether fetch should be redirected to a cached target. It is trained by resolved conditional branches and JALs from execute.

## Interface
- `ENTRIES`, default 16: number of table entries; must be a power of 2, minimum 2.
- `IDX_W`, default $clog2(ENTRIES): index width; derived, not overridden.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `lookup_valid`  input  1  `lookup_pc` holds a real decode-stage instruction.
- `lookup_pc`  input  32  PC of the decode-stage instruction.
- `pred_taken`  output  1  redirect fetch; connects to the PC `target_taken` input.
- `pred_target`  output  32  predicted target; connects to the PC `target` input.
- `pred_hit`  output  1  valid tag match; piped down with the instruction for training.
- `upd_valid`  input  1  a resolved branch or jump is reported this cycle.
- `upd_pc`  input  32  PC of the resolved instruction.
- `upd_is_jal`  input  1  1 = JAL, 0 = conditional branch. JALR is never reported.
- `upd_taken`  input  1  resolved direction; always 1 for JAL.
- `upd_target`  input  32  resolved target address.

## Operation
- **Address split.** Index = `pc[IDX_W+1:2]`. Tag = `pc[31:IDX_W+2]`. `pc[1:0]` is ignored.
- **Entry contents.** valid (1), tag, target (32), ctr (2), jal (1).
- **Lookup (combinational).**
  - hit = `lookup_valid` & `valid[idx]` & (`tag[idx]` == lookup tag).
  - `pred_hit` = hit.
  - `pred_taken` = hit & (`jal[idx]` | `ctr[idx][1]`).
  - `pred_target` = `target[idx]` when hit, else 0.
- **Update when `upd_valid` and the entry at the index hits on `upd_pc`:**
  - Conditional branch, taken: ctr increments, saturating at 3. target <= `upd_target`.
  - Conditional branch, not taken: ctr decrements, saturating at 0. target unchanged.
  - JAL: ctr <= 3, jal <= 1, target <= `upd_target`.
- **Update when `upd_valid` and the entry misses (invalid or tag mismatch):**
  - If `upd_taken`: allocate and overwrite the entry. valid <= 1, tag, target, jal <= `upd_is_jal`, ctr <= 3 if JAL else 2 (weakly taken).
  - If not taken: no allocation; the table is unchanged.
- **Replacement.** Direct-mapped. An allocation evicts whatever is at the index unconditionally.
- **Reset.** All valid bits clear in one cycle. Tag, target, ctr and jal are don't-care after reset; they are never visible while valid = 0.
- **No internal state machine.** The only state is the table. There is no stall input; lookups are pure and have no side effects.

## Timing
- Lookup is zero-latency. Outputs are a function of the current `lookup_pc`/`lookup_valid` and registered table state only. There is no path from the `upd_*` inputs to the `pred_*` outputs.
- An update is visible to lookups starting the cycle after `upd_valid`.
- **Lookup and update in the same cycle, same index:** lookup returns the pre-update contents (no write-through).
- **Reset outputs:**
  - While `rst` is high, `pred_taken` = 0, `pred_hit` = 0, `pred_target` = 0, regardless of other inputs.
  - In the first cycle after `rst` deasserts, every lookup misses.
  - An update presented while `rst` is high is dropped.
- **Reset asserted mid-operation:** an update in flight that cycle is discarded. The table is empty the next cycle.
- Counter arithmetic is 2-bit saturating; it never wraps 3→0 or 0→3.
- `pred_target` is a 32-bit copy of `upd_target` with no alignment masking.

## Test plan
- **Reset state:** ENTRIES=16. Reset, then look up 0x4000_0010 → `pred_hit`=0, `pred_taken`=0, `pred_target`=0.
- **Allocate and strengthen:** taken branch update (pc 0x4000_0010, target 0x4000_0100), then lookup → hit, `pred_taken`=1, target 0x4000_0100, ctr 2. A further taken update → ctr 3. A further taken update → ctr stays 3.
- **Hysteresis and saturation:** from ctr 3, two not-taken updates → `pred_taken` stays 1 after the first (ctr 2) and becomes 0 after the second (ctr 1). Two more not-taken updates → ctr stays 0; `pred_hit`=1, `pred_taken`=0.
- **Aliasing and no-allocate:**
  - Not-taken update at 0x4000_0050 (same index 4) → the 0x4000_0010 entry is unchanged.
  - Taken update at 0x4000_0050 → lookup 0x4000_0010 misses; lookup 0x4000_0050 hits.
- **Same-cycle collision:** lookup 0x4000_0020 while a taken JAL update to 0x4000_0020 (target 0x4000_0200) occurs → `pred_hit`=0 in that cycle. Next cycle: `pred_hit`=1, `pred_taken`=1, `pred_target`=0x4000_0200.
- **Reset mid-operation:** assert `rst` together with an update → during reset all outputs are 0. After reset, all previously trained PCs miss, and the dropped update is absent.
